tx_lane_scrambler: RTL and testbench
====================================

Name: tx_lane_scrambler

Overview:
Per-lane PCIe Gen1/Gen2 data scrambler. It sits directly downstream of the data lane striper and upstream of the per-lane 8b/10b encoders. On each striper "go" strobe it takes one symbol per lane and scrambles data (D) symbols with a 16-bit LFSR. K symbols pass through unscrambled, with COM/SKP rules applied to the LFSR. Output is a one-entry registered stage with a valid/ready handshake toward the encoders.

Parameters:
NUM_LANES, 4, number of lanes; one independent LFSR per lane.
DATA_WIDTH, 8, symbol width; only 8 is supported (elaboration error otherwise).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lane_data_i  in  DATA_WIDTH x NUM_LANES  striped symbols, one per lane
lane_data_valid_i  in  1 x NUM_LANES  per-lane enable (lane carries a symbol)
lane_is_k_i  in  1 x NUM_LANES  symbol is a K code
stripe_tx_go_i  in  1  striper strobe: all enabled lanes loaded
stripe_ready_o  out  1  block can accept the strobe this cycle
scramble_disable_i  in  1  bypass scrambling; LFSRs still advance
scr_data_o  out  DATA_WIDTH x NUM_LANES  scrambled symbols
scr_is_k_o  out  1 x NUM_LANES  K flag, registered alongside the data
scr_valid_o  out  1 x NUM_LANES  per-lane output valid
enc_ready_i  in  1  encoders accept the output this cycle

Behaviour:
- Reset (async assert, sync release):
  - every LFSR = 16'hFFFF
  - scr_data_o = 0, scr_is_k_o = 0, scr_valid_o = 0
  - output register empty
- Reset mid-operation discards the held output. No partial state survives reset.
- stripe_ready_o = output register empty OR enc_ready_i (combinational).
- Accept condition: stripe_tx_go_i && stripe_ready_o.
  - On accept, the output register loads the result on the next clock edge: latency 1 cycle.
  - stripe_tx_go_i while not ready is ignored. The striper holds the strobe until ready.
- Output handshake:
  - Output register is "full" when any scr_valid_o bit is set.
  - Transfer completes when full && enc_ready_i.
  - With no new accept in that cycle, scr_valid_o clears next cycle.
  - Simultaneous transfer and accept overwrites the register in the same cycle (full throughput, one lane-set per cycle).
  - While full && !enc_ready_i, all outputs and all LFSRs hold.
- Per lane, on accept, with lane_data_valid_i[l] = 1:
  - K = COM (8'hBC): output unchanged; LFSR[l] <= 16'hFFFF.
  - K = SKP (8'h1C): output unchanged; LFSR[l] holds.
  - Other K: output unchanged; LFSR[l] advances 8 steps.
  - D symbol: output = data XOR key; LFSR[l] advances 8 steps. With scramble_disable_i = 1, output = data, but the LFSR still advances.
- Per lane, on accept, with lane_data_valid_i[l] = 0: scr_valid_o[l] = 0, LFSR[l] holds, data output = 0.
- scr_is_k_o[l] = lane_is_k_i[l], registered on accept.
- LFSR (Galois form, G(X) = X^16+X^5+X^4+X^3+1), one step for key bit i = 0..7 (bit 0 first):
  - key[i] = lfsr[15]
  - lfsr <= {lfsr[14:0], 1'b0}
  - if the old lfsr[15] = 1: XOR in 16'h0039 (bits 0, 3, 4, 5).
  - The 8 steps are computed combinationally within one cycle.
- Lanes are fully independent. Identical stimulus on all lanes yields identical outputs.

Test Plan:
- Reset, then COM on all lanes, then D 8'h00, 8'h00 -> scr_data_o per lane BC (k=1), FF, 17 on consecutive transfers, each 1 cycle after accept.
- COM, SKP, D 8'h00 -> outputs BC, 1C, FF: SKP does not advance the LFSR.
- Back-to-back accepts with enc_ready_i held low for 3 cycles -> outputs and stripe_ready_o=0 hold; no symbol lost or duplicated; sequence resumes FF, 17.
- scramble_disable_i=1 with D 8'hA5 after COM, then disable=0 with D 8'h00 -> A5, then 17: the LFSR advanced during bypass.
- lane_data_valid_i = {1,1,0,0} -> lanes 2/3 have scr_valid_o=0 and LFSRs frozen; when re-enabled, they continue from their frozen state.
- Assert rst_ni low while output is full and enc_ready_i=0 -> scr_valid_o=0 immediately (async); after release, the LFSR restarts at FFFF (D 00 -> FF).

Source files
------------

// File: rtl/tx_lane_scrambler.sv
// tx_lane_scrambler: per-lane PCIe Gen1/Gen2 scrambler between the lane striper and 8b/10b encoders.
// Revision: 1.0
`default_nettype none

module tx_lane_scrambler #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_data_i,
  input  logic [NUM_LANES-1:0]                  lane_data_valid_i,
  input  logic [NUM_LANES-1:0]                  lane_is_k_i,
  input  logic                                  stripe_tx_go_i,
  output logic                                  stripe_ready_o,
  input  logic                                  scramble_disable_i,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  scr_data_o,
  output logic [NUM_LANES-1:0]                  scr_is_k_o,
  output logic [NUM_LANES-1:0]                  scr_valid_o,
  input  logic                                  enc_ready_i
);

  localparam logic [7:0]  c_com       = 8'hBC;
  localparam logic [7:0]  c_skp       = 8'h1C;
  localparam logic [15:0] c_lfsr_seed = 16'hFFFF;
  localparam logic [15:0] c_lfsr_taps = 16'h0039;

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("tx_lane_scrambler supports DATA_WIDTH == 8 only");
  end

  // Eight Galois steps of X^16+X^5+X^4+X^3+1; returns {key[7:0], next_state[15:0]}.
  function automatic logic [23:0] lfsr_step8(input logic [15:0] state);
    logic [15:0] s;
    logic [7:0]  k;
    s = state;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[15];
      s    = s[15] ? ({s[14:0], 1'b0} ^ c_lfsr_taps) : {s[14:0], 1'b0};
    end
    return {k, s};
  endfunction

  logic                                 w_full;
  logic                                 w_accept;
  logic                                 w_drain;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data_d;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] scr_data_q;
  logic [NUM_LANES-1:0]                 scr_is_k_q;
  logic [NUM_LANES-1:0]                 scr_valid_q;

  assign w_full         = |scr_valid_q;
  assign stripe_ready_o = !w_full || enc_ready_i;
  assign w_accept       = stripe_tx_go_i && stripe_ready_o;
  assign w_drain        = w_full && enc_ready_i;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [23:0] w_step;
    logic [7:0]  w_sym;

    assign w_step = lfsr_step8(lfsr_q);

    always_comb begin
      lfsr_d = lfsr_q;
      w_sym  = '0;
      if (lane_data_valid_i[l]) begin
        if (lane_is_k_i[l]) begin
          w_sym = lane_data_i[l];
          if (lane_data_i[l] == c_com) begin
            lfsr_d = c_lfsr_seed;
          end else if (lane_data_i[l] != c_skp) begin
            lfsr_d = w_step[15:0];
          end
        end else begin
          // Bypass still consumes a key so the far-end descrambler stays aligned.
          w_sym  = scramble_disable_i ? lane_data_i[l] : (lane_data_i[l] ^ w_step[23:16]);
          lfsr_d = w_step[15:0];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr_q <= c_lfsr_seed;
      end else if (w_accept) begin
        lfsr_q <= lfsr_d;
      end
    end

    assign data_d[l] = w_sym;
  end

  // Simultaneous drain and accept simply overwrites, giving one lane-set per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scr_data_q  <= '0;
      scr_is_k_q  <= '0;
      scr_valid_q <= '0;
    end else if (w_accept) begin
      scr_data_q  <= data_d;
      scr_is_k_q  <= lane_is_k_i;
      scr_valid_q <= lane_data_valid_i;
    end else if (w_drain) begin
      scr_valid_q <= '0;
    end
  end

  assign scr_data_o  = scr_data_q;
  assign scr_is_k_o  = scr_is_k_q;
  assign scr_valid_o = scr_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_lane_scrambler.sv
// tb_tx_lane_scrambler: directed self-checking bench for tx_lane_scrambler.
// Revision: 1.0
`default_nettype none

module tb_tx_lane_scrambler;

  localparam int NL = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NL-1:0][7:0] lane_data_i = '0;
  logic [NL-1:0]     lane_data_valid_i = '0;
  logic [NL-1:0]     lane_is_k_i = '0;
  logic              stripe_tx_go_i = 1'b0;
  logic              stripe_ready_o;
  logic              scramble_disable_i = 1'b0;
  logic [NL-1:0][7:0] scr_data_o;
  logic [NL-1:0]     scr_is_k_o;
  logic [NL-1:0]     scr_valid_o;
  logic              enc_ready_i = 1'b1;

  int total = 0;
  int bad   = 0;

  tx_lane_scrambler #(.NUM_LANES(NL), .DATA_WIDTH(8)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .lane_data_i        (lane_data_i),
    .lane_data_valid_i  (lane_data_valid_i),
    .lane_is_k_i        (lane_is_k_i),
    .stripe_tx_go_i     (stripe_tx_go_i),
    .stripe_ready_o     (stripe_ready_o),
    .scramble_disable_i (scramble_disable_i),
    .scr_data_o         (scr_data_o),
    .scr_is_k_o         (scr_is_k_o),
    .scr_valid_o        (scr_valid_o),
    .enc_ready_i        (enc_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Presents one lane-set with go high across a posedge; leaves go low at the following negedge.
  task automatic drive(input logic [7:0] d, input logic k, input logic [NL-1:0] v);
    for (int l = 0; l < NL; l++) lane_data_i[l] = d;
    lane_is_k_i       = {NL{k}};
    lane_data_valid_i = v;
    stripe_tx_go_i    = 1'b1;
    @(negedge clk_i);
    stripe_tx_go_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    enc_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++;
    if (scr_valid_o !== '0 || scr_data_o !== '0 || scr_is_k_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%h data=%h k=%h expected all 0", scr_valid_o, scr_data_o, scr_is_k_o);
    end
    total++;
    if (stripe_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b expected 1", stripe_ready_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_com_data();
    logic [7:0] exp_d [3];
    logic       exp_k [3];
    exp_d = '{8'hBC, 8'hFF, 8'h17};
    exp_k = '{1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 3; s++) begin
      drive((s == 0) ? 8'hBC : 8'h00, exp_k[s], 4'hF);
      for (int l = 0; l < NL; l++) begin
        total++;
        if (scr_data_o[l] !== exp_d[s] || scr_is_k_o[l] !== exp_k[s] || scr_valid_o[l] !== 1'b1) begin
          bad++;
          $display("FAIL com_data step%0d lane%0d: data=%h k=%b v=%b expected data=%h k=%b v=1",
                   s, l, scr_data_o[l], scr_is_k_o[l], scr_valid_o[l], exp_d[s], exp_k[s]);
        end
      end
    end
    @(negedge clk_i);
    total++;
    if (scr_valid_o !== '0) begin
      bad++;
      $display("FAIL drain_clear: valid=%h expected 0", scr_valid_o);
    end
  endtask

  task automatic test_skp();
    drive(8'hBC, 1'b1, 4'hF);
    drive(8'h1C, 1'b1, 4'hF);
    total++;
    if (scr_data_o !== {NL{8'h1C}} || scr_is_k_o !== 4'hF) begin
      bad++;
      $display("FAIL skp_pass: data=%h k=%h expected data=1c1c1c1c k=f", scr_data_o, scr_is_k_o);
    end
    drive(8'h00, 1'b0, 4'hF);
    total++;
    if (scr_data_o !== {NL{8'hFF}}) begin
      bad++;
      $display("FAIL skp_no_advance: data=%h expected ffffffff", scr_data_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    drive(8'hBC, 1'b1, 4'hF);
    enc_ready_i = 1'b0;
    for (int l = 0; l < NL; l++) lane_data_i[l] = 8'h00;
    lane_is_k_i       = '0;
    lane_data_valid_i = 4'hF;
    stripe_tx_go_i    = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (stripe_ready_o !== 1'b0 || scr_data_o !== {NL{8'hBC}} || scr_valid_o !== 4'hF) begin
        bad++;
        $display("FAIL stall_hold cyc%0d: ready=%b data=%h v=%h expected ready=0 data=bcbcbcbc v=f",
                 c, stripe_ready_o, scr_data_o, scr_valid_o);
      end
      @(negedge clk_i);
    end
    enc_ready_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (scr_data_o !== {NL{8'hFF}} || scr_valid_o !== 4'hF) begin
      bad++;
      $display("FAIL stall_resume1: data=%h v=%h expected ffffffff v=f", scr_data_o, scr_valid_o);
    end
    @(negedge clk_i);
    stripe_tx_go_i = 1'b0;
    total++;
    if (scr_data_o !== {NL{8'h17}} || scr_valid_o !== 4'hF) begin
      bad++;
      $display("FAIL stall_resume2: data=%h v=%h expected 17171717 v=f", scr_data_o, scr_valid_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_disable();
    drive(8'hBC, 1'b1, 4'hF);
    scramble_disable_i = 1'b1;
    drive(8'hA5, 1'b0, 4'hF);
    scramble_disable_i = 1'b0;
    total++;
    if (scr_data_o !== {NL{8'hA5}}) begin
      bad++;
      $display("FAIL bypass_data: data=%h expected a5a5a5a5", scr_data_o);
    end
    drive(8'h00, 1'b0, 4'hF);
    total++;
    if (scr_data_o !== {NL{8'h17}}) begin
      bad++;
      $display("FAIL bypass_advance: data=%h expected 17171717", scr_data_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_lane_valid();
    drive(8'hBC, 1'b1, 4'hF);
    drive(8'h00, 1'b0, 4'b0011);
    total++;
    if (scr_valid_o !== 4'b0011 || scr_data_o !== 32'h0000_FFFF) begin
      bad++;
      $display("FAIL lane_mask: v=%h data=%h expected v=3 data=0000ffff", scr_valid_o, scr_data_o);
    end
    drive(8'h00, 1'b0, 4'hF);
    total++;
    if (scr_valid_o !== 4'hF || scr_data_o !== 32'hFFFF_1717) begin
      bad++;
      $display("FAIL lane_frozen: v=%h data=%h expected v=f data=ffff1717", scr_valid_o, scr_data_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    drive(8'hBC, 1'b1, 4'hF);
    drive(8'h00, 1'b0, 4'hF);
    enc_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (scr_valid_o !== '0 || scr_data_o !== '0) begin
      bad++;
      $display("FAIL async_reset: v=%h data=%h expected 0", scr_valid_o, scr_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    enc_ready_i = 1'b1;
    @(negedge clk_i);
    drive(8'h00, 1'b0, 4'hF);
    total++;
    if (scr_data_o !== {NL{8'hFF}} || scr_valid_o !== 4'hF) begin
      bad++;
      $display("FAIL reset_reseed: data=%h v=%h expected ffffffff v=f", scr_data_o, scr_valid_o);
    end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_com_data();
    test_skp();
    test_back_to_back();
    test_disable();
    test_lane_valid();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
